bsg_dispatch_fixed: RTL

Fixed-priority 1-to-N dispatcher; the fan-out counterpart of the fixed-priority N-to-1 arbiter.
- Accepts a single ready/valid input stream.
- Writes each accepted word into the lowest-index empty per-channel holding register.
- Each channel drains independently through a valid/yumi handshake.
- Sits in front of replicated worker units, such as N identical pipelines fed from one request queue.

---
 rtl/bsg_dispatch_fixed_pkg.sv | 14 +
 rtl/bsg_dispatch_fixed_if.sv | 30 +++
 rtl/bsg_dispatch_fixed_chan.sv | 32 +++
 rtl/bsg_dispatch_fixed.sv | 81 ++++++++
 4 files changed

// File: rtl/bsg_dispatch_fixed_pkg.sv
// Shared helpers for the fixed-priority dispatcher: index and count width derivation.
package bsg_dispatch_fixed_pkg;

    // Never returns 0 so that single-element vectors still get a one-bit index.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned width_of(input int unsigned n);
        return safe_clog2(n + 1);
    endfunction

endpackage

// File: rtl/bsg_dispatch_fixed_if.sv
// Input stream, per-channel drain handshake and status of the fixed-priority dispatcher.
interface bsg_dispatch_fixed_if #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 8
);
    import bsg_dispatch_fixed_pkg::*;

    localparam int unsigned lg_els_lp = safe_clog2(els_p);
    localparam int unsigned lg_cnt_lp = width_of(els_p);

    logic                       v_i;
    logic [width_p-1:0]         data_i;
    logic                       ready_o;
    logic [els_p-1:0]           v_o;
    logic [els_p*width_p-1:0]   data_o;
    logic [els_p-1:0]           yumi_i;
    logic [lg_els_lp-1:0]       sent_id_o;
    logic [lg_cnt_lp-1:0]       count_o;

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, sent_id_o, count_o
    );

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, sent_id_o, count_o
    );

endinterface

// File: rtl/bsg_dispatch_fixed_chan.sv
// One-entry holding register: filled by the dispatcher, cleared by its consumer's yumi.
module bsg_dispatch_fixed_chan #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               fill_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);
    logic               r_full;
    logic [width_p-1:0] r_data;

    // Fill only ever targets an empty channel, so it cannot collide with a drain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (fill_i) begin
            r_full <= 1'b1;
            r_data <= data_i;
        end else if (yumi_i && r_full) begin
            r_full <= 1'b0;
        end
    end

    assign v_o    = r_full;
    assign data_o = r_data;

endmodule

// File: rtl/bsg_dispatch_fixed.sv
// Fixed-priority 1-to-N dispatcher: each accepted word goes to the lowest-index empty channel.
module bsg_dispatch_fixed #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bsg_dispatch_fixed_if.slave     io
);
    import bsg_dispatch_fixed_pkg::*;

    localparam int unsigned lg_els_lp = safe_clog2(els_p);
    localparam int unsigned lg_cnt_lp = width_of(els_p);

    logic [els_p-1:0]              w_full;
    logic [els_p-1:0]              w_free;
    logic [els_p-1:0]              w_target;
    logic [els_p-1:0]              w_drain;
    logic [lg_els_lp-1:0]          w_sent_id;
    logic [lg_cnt_lp-1:0]          w_pop;
    logic [els_p-1:0][width_p-1:0] w_data;
    logic                          w_accept;
    logic [lg_cnt_lp-1:0]          r_count;

    assign w_free   = ~w_full;
    assign w_accept = io.v_i & (|w_free);
    assign w_drain  = io.yumi_i & w_full;

    // Descending scan so the lowest free index wins.
    always_comb begin
        w_target  = '0;
        w_sent_id = '0;
        for (int i = int'(els_p) - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_target    = '0;
                w_target[i] = 1'b1;
                w_sent_id   = lg_els_lp'(i);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(els_p); i++) begin
            w_pop = w_pop + lg_cnt_lp'(w_drain[i]);
        end
    end

    for (genvar g = 0; g < int'(els_p); g++) begin : g_chan
        bsg_dispatch_fixed_chan #(
            .width_p (width_p)
        ) u_chan (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .fill_i  (w_accept & w_target[g]),
            .data_i  (io.data_i),
            .yumi_i  (io.yumi_i[g]),
            .v_o     (w_full[g]),
            .data_o  (w_data[g])
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + lg_cnt_lp'(w_accept) - w_pop;
        end
    end

    assign io.ready_o   = |w_free;
    assign io.sent_id_o = w_sent_id;
    assign io.v_o       = w_full;
    assign io.data_o    = w_data;
    assign io.count_o   = r_count;

    // Consuming an empty channel is a protocol error on the consumer side.
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        (io.yumi_i & ~w_full) == '0);

endmodule
